// File: rtl/sayac_kuyruk.sv
// sayac_kuyruk
// Buffers result pulses from an upstream counter in a small circular FIFO
// and replays them, one job at a time, as start commands to a downstream
// counter. A new job is issued only after the previous one has reported
// completion, so the two stages are decoupled without losing results.
//
// Optional feature macro: SAYAC_KUYRUK_DONUSUM_EN
//   defined   : cikis_yon = ~yon, cikis_miktar = saturating miktar+1
//   undefined : fields pass through unchanged
//
// Parameters:
//   DERINLIK               FIFO depth in entries (power of 2, >= 2)
// Ports:
//   saat                   clock, rising edge
//   reset_n                synchronous active-low reset
//   giris_hazir            upstream done pulse (push request)
//   giris_sonuc[7:0]       upstream result
//   giris_yon              upstream direction (1 = up)
//   giris_miktar[2:0]      upstream step size
//   hedef_mesgul           downstream counter busy
//   hedef_hazir            downstream counter done pulse
//   cikis_basla            one-cycle start pulse to downstream
//   cikis_baslangic_degeri start value, held until next issue
//   cikis_yon              direction, held until next issue
//   cikis_miktar[2:0]      step, held until next issue
//   bos / dolu             FIFO empty / full
//   sayi                   FIFO occupancy
//   tasma                  sticky overflow flag
//   tamamlanan[7:0]        finished downstream jobs (wrapping)

module sayac_kuyruk #(
  parameter int DERINLIK = 4
) (
  input  logic                      saat,
  input  logic                      reset_n,
  input  logic                      giris_hazir,
  input  logic [7:0]                giris_sonuc,
  input  logic                      giris_yon,
  input  logic [2:0]                giris_miktar,
  input  logic                      hedef_mesgul,
  input  logic                      hedef_hazir,
  output logic                      cikis_basla,
  output logic [7:0]                cikis_baslangic_degeri,
  output logic                      cikis_yon,
  output logic [2:0]                cikis_miktar,
  output logic                      bos,
  output logic                      dolu,
  output logic [$clog2(DERINLIK):0] sayi,
  output logic                      tasma,
  output logic [7:0]                tamamlanan
);

  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DERINLIK);

  typedef enum logic [1:0] {BOSTA, BASLAT, BEKLE} durum_t;

  durum_t        state_reg, state_next;

  // Entry layout: {sonuc[7:0], yon, miktar[2:0]}
  logic [11:0]   mem_reg [DERINLIK];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   sayi_reg, sayi_next;
  logic          bos_reg, dolu_reg, tasma_reg;
  logic          basla_reg;
  logic [7:0]    deger_reg;
  logic          yon_reg;
  logic [2:0]    miktar_reg;
  logic [7:0]    tamamlanan_reg;

  logic          pop, push, overflow;
  logic [11:0]   head;
  logic          yon_next;
  logic [2:0]    miktar_next;

  assign head = mem_reg[rd_ptr_reg];

  // Issue only from idle with something queued and the target free.
  // A pop on the same edge frees a slot, so a push into a full FIFO is
  // still accepted then.
  always_comb begin
    pop      = (state_reg == BOSTA) && !bos_reg && !hedef_mesgul;
    push     = giris_hazir && (!dolu_reg || pop);
    overflow = giris_hazir && dolu_reg && !pop;
  end

  always_comb begin
    sayi_next = sayi_reg;
    case ({push, pop})
      2'b10:   sayi_next = sayi_reg + CNT_ONE;
      2'b01:   sayi_next = sayi_reg - CNT_ONE;
      default: sayi_next = sayi_reg;
    endcase
  end

  // Field transform applied to the head entry on issue
  always_comb begin
`ifdef SAYAC_KUYRUK_DONUSUM_EN
    yon_next    = ~head[3];
    miktar_next = (head[2:0] == 3'd7) ? 3'd7 : head[2:0] + 3'd1;
`else
    yon_next    = head[3];
    miktar_next = head[2:0];
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOSTA:   if (pop) state_next = BASLAT;
      BASLAT:  state_next = BEKLE;
      BEKLE:   if (hedef_hazir) state_next = BOSTA;
      default: state_next = BOSTA;
    endcase
  end

  // Storage array is not reset; pointers/occupancy define validity.
  always_ff @(posedge saat) begin
    if (reset_n && push) begin
      mem_reg[wr_ptr_reg] <= {giris_sonuc, giris_yon, giris_miktar};
    end
  end

  always_ff @(posedge saat) begin
    if (!reset_n) begin
      state_reg      <= BOSTA;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      sayi_reg       <= '0;
      bos_reg        <= 1'b1;
      dolu_reg       <= 1'b0;
      tasma_reg      <= 1'b0;
      basla_reg      <= 1'b0;
      deger_reg      <= '0;
      yon_reg        <= 1'b0;
      miktar_reg     <= '0;
      tamamlanan_reg <= '0;
    end else begin
      state_reg <= state_next;
      sayi_reg  <= sayi_next;
      bos_reg   <= (sayi_next == '0);
      dolu_reg  <= (sayi_next == CNT_FULL);
      basla_reg <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        deger_reg  <= head[11:4];
        yon_reg    <= yon_next;
        miktar_reg <= miktar_next;
      end
      if (overflow) tasma_reg <= 1'b1;
      // Done pulses outside BEKLE belong to no job of ours and are ignored
      if (state_reg == BEKLE && hedef_hazir) tamamlanan_reg <= tamamlanan_reg + 8'd1;
    end
  end

  assign cikis_basla            = basla_reg;
  assign cikis_baslangic_degeri = deger_reg;
  assign cikis_yon              = yon_reg;
  assign cikis_miktar           = miktar_reg;
  assign bos                    = bos_reg;
  assign dolu                   = dolu_reg;
  assign sayi                   = sayi_reg;
  assign tasma                  = tasma_reg;
  assign tamamlanan             = tamamlanan_reg;

endmodule

// File: tb/tb_sayac_kuyruk.sv
module tb_sayac_kuyruk;

  localparam int D = 4;

  logic       saat = 1'b0;
  logic       reset_n;
  logic       giris_hazir;
  logic [7:0] giris_sonuc;
  logic       giris_yon;
  logic [2:0] giris_miktar;
  logic       hedef_mesgul;
  logic       hedef_hazir;
  logic       cikis_basla;
  logic [7:0] cikis_baslangic_degeri;
  logic       cikis_yon;
  logic [2:0] cikis_miktar;
  logic       bos, dolu, tasma;
  logic [2:0] sayi;
  logic [7:0] tamamlanan;

  int total = 0;
  int bad = 0;

  sayac_kuyruk #(.DERINLIK(D)) dut (
    .saat(saat), .reset_n(reset_n),
    .giris_hazir(giris_hazir), .giris_sonuc(giris_sonuc),
    .giris_yon(giris_yon), .giris_miktar(giris_miktar),
    .hedef_mesgul(hedef_mesgul), .hedef_hazir(hedef_hazir),
    .cikis_basla(cikis_basla), .cikis_baslangic_degeri(cikis_baslangic_degeri),
    .cikis_yon(cikis_yon), .cikis_miktar(cikis_miktar),
    .bos(bos), .dolu(dolu), .sayi(sayi), .tasma(tasma), .tamamlanan(tamamlanan)
  );

  always #5 saat = ~saat;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] deger;
    logic       yon;
    logic [2:0] miktar;
  } is_t;

  is_t        mq[$];      // queued upstream results
  is_t        exp_q[$];   // jobs the model says were issued (scoreboard)
  int         phase = 0;  // 0 idle, 1 start just issued, 2 waiting
  int         m_done = 0;
  bit         m_ovf = 0;
  bit         m_basla = 0;
  is_t        m_held = '{8'd0, 1'b0, 3'd0};
  bit         started = 0;

  function automatic is_t donustur(is_t e);
    is_t r;
    r.deger = e.deger;
`ifdef SAYAC_KUYRUK_DONUSUM_EN
    r.yon = !e.yon;
    r.miktar = (e.miktar == 3'd7) ? 3'd7 : 3'(e.miktar + 1);
`else
    r.yon = e.yon;
    r.miktar = e.miktar;
`endif
    return r;
  endfunction

  always @(posedge saat) begin
    bit   issue;
    is_t  e;
    started = 1;
    if (!reset_n) begin
      mq.delete();
      phase = 0; m_done = 0; m_ovf = 0; m_basla = 0;
      m_held = '{8'd0, 1'b0, 3'd0};
    end else begin
      issue = (phase == 0) && (mq.size() > 0) && !hedef_mesgul;
      if (phase == 2 && hedef_hazir) begin
        m_done = (m_done + 1) % 256;
        phase = 0;
      end else if (phase == 1) begin
        phase = 2;
      end
      if (issue) begin
        e = mq.pop_front();
        m_held = donustur(e);
        exp_q.push_back(m_held);
        phase = 1;
      end
      m_basla = issue;
      if (giris_hazir) begin
        if (mq.size() < D) mq.push_back('{giris_sonuc, giris_yon, giris_miktar});
        else m_ovf = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic chk(input string n, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, act, expv);
    end
  endtask

  always @(negedge saat) begin
    is_t x;
    if (started) begin
      chk("sayi", int'(sayi), mq.size());
      chk("bos", int'(bos), int'(mq.size() == 0));
      chk("dolu", int'(dolu), int'(mq.size() == D));
      chk("tasma", int'(tasma), int'(m_ovf));
      chk("tamamlanan", int'(tamamlanan), m_done);
      chk("basla", int'(cikis_basla), int'(m_basla));
      chk("deger", int'(cikis_baslangic_degeri), int'(m_held.deger));
      chk("yon", int'(cikis_yon), int'(m_held.yon));
      chk("miktar", int'(cikis_miktar), int'(m_held.miktar));
      if (cikis_basla) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("issue_value", int'({cikis_baslangic_degeri, cikis_yon, cikis_miktar}),
              int'({x.deger, x.yon, x.miktar}));
          $display("issue t=%0t deger=%0d yon=%0d miktar=%0d", $time,
                   cikis_baslangic_degeri, cikis_yon, cikis_miktar);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic adim(input bit h, input logic [7:0] s, input bit y, input logic [2:0] m,
                      input bit mes, input bit hh, input bit rn);
    giris_hazir = h; giris_sonuc = s; giris_yon = y; giris_miktar = m;
    hedef_mesgul = mes; hedef_hazir = hh; reset_n = rn;
    @(posedge saat);
    #2;
  endtask

  task automatic bos_adim(input int n, input bit mes);
    for (int i = 0; i < n; i++) adim(0, 8'd0, 0, 3'd0, mes, 0, 1);
  endtask

  initial begin
    adim(0, 8'd0, 0, 3'd0, 0, 0, 0);
    adim(0, 8'd0, 0, 3'd0, 0, 0, 0);

    // single job
    adim(1, 8'd136, 1, 3'd3, 0, 0, 1);
    bos_adim(3, 0);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    bos_adim(2, 0);

    // saturation
    adim(1, 8'd200, 0, 3'd7, 0, 0, 1);
    bos_adim(3, 0);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    bos_adim(2, 0);

    // premature / idle done pulses
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    adim(1, 8'd55, 1, 3'd0, 0, 0, 1);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    bos_adim(2, 0);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    bos_adim(2, 0);

    // fill and overflow
    for (int i = 0; i < 5; i++) adim(1, 8'(10 + i), i[0], 3'(i), 1, 0, 1);
    bos_adim(2, 1);
    for (int i = 0; i < 4; i++) begin
      bos_adim(2, 0);
      adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    end
    bos_adim(2, 0);

    // full with simultaneous push and pop
    adim(0, 8'd0, 0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) adim(1, 8'(20 + i), 1, 3'd2, 1, 0, 1);
    adim(1, 8'd99, 0, 3'd5, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      bos_adim(2, 0);
      adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    end
    bos_adim(2, 0);

    // reset mid-operation
    adim(1, 8'd70, 1, 3'd1, 0, 0, 1);
    for (int i = 0; i < 3; i++) adim(1, 8'(71 + i), 0, 3'd4, 0, 0, 1);
    adim(1, 8'd90, 1, 3'd6, 0, 0, 0);
    bos_adim(2, 0);
    adim(1, 8'd33, 0, 3'd6, 0, 0, 1);
    bos_adim(3, 0);
    adim(0, 8'd0, 0, 3'd0, 0, 1, 1);
    bos_adim(2, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      adim($urandom_range(0, 99) < 40, 8'($urandom), 1'($urandom), 3'($urandom),
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
           $urandom_range(0, 199) != 0);
    end

    // drain
    for (int i = 0; i < 40; i++) adim(0, 8'd0, 0, 3'd0, 0, $urandom_range(0, 1) == 1, 1);
    chk("drained_scoreboard", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sayac_kuyruk.md
# sayac_kuyruk

- Receiving end of the counter-done handshake.
- Captures every `hazir` result pulse from an upstream `sayac` into a small FIFO.
- Replays the queued results as `basla` commands to a downstream `sayac`, one at a time, gated by the downstream counter's completion.
- Sits between two counter stages and decouples them, so upstream results are never lost while the downstream counter is busy.

## Interface
- `DERINLIK`, default 4: FIFO depth in entries; must be a power of 2, ≥ 2.
- `saat`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `giris_hazir`  in  1  upstream done pulse; one entry is pushed per cycle it is high.
- `giris_sonuc`  in  8  upstream result, sampled with `giris_hazir`.
- `giris_yon`  in  1  upstream count direction (1 = up), sampled with `giris_hazir`.
- `giris_miktar`  in  3  upstream step size, sampled with `giris_hazir`.
- `hedef_mesgul`  in  1  downstream counter busy.
- `hedef_hazir`  in  1  downstream counter done pulse.
- `cikis_basla`  out  1  one-cycle start pulse to the downstream counter.
- `cikis_baslangic_degeri`  out  8  start value, valid while `cikis_basla`=1 and held until the next issue.
- `cikis_yon`  out  1  direction for the downstream counter, held like the start value.
- `cikis_miktar`  out  3  step for the downstream counter, held like the start value.
- `bos`  out  1  FIFO empty.
- `dolu`  out  1  FIFO full.
- `sayi`  out  $clog2(DERINLIK)+1  entries currently queued.
- `tasma`  out  1  sticky overflow flag.
- `tamamlanan`  out  8  count of finished downstream jobs; wraps 255→0.

## Operation
- **FIFO:** circular buffer of {sonuc[7:0], yon, miktar[2:0]}.
  - Write and read pointers are log2(DERINLIK) bits and wrap naturally.
  - `sayi` tracks occupancy.
- **Push:** on any edge where `giris_hazir`=1 and (not full, or a pop occurs on the same edge).
- **Overflow:** `giris_hazir`=1 while full with no pop on that edge.
  - The entry is dropped.
  - `tasma` is set to 1 and holds until reset.
  - FIFO contents are unchanged.
- **FSM states:**
  - `BOSTA` (idle)
  - `BASLAT` (start issued)
  - `BEKLE` (waiting for downstream)
- **Transitions:**
  - `BOSTA` → `BASLAT`: when `bos`=0 and `hedef_mesgul`=0.
    - The head entry is popped on this edge.
    - Its transformed fields are registered onto the `cikis_*` data outputs.
    - `cikis_basla` is registered to 1.
  - `BASLAT` → `BEKLE`: unconditional, next edge; `cikis_basla` returns to 0.
  - `BEKLE` → `BOSTA`: on an edge with `hedef_hazir`=1; `tamamlanan` increments on that edge.
  - `hedef_hazir` in `BOSTA` or `BASLAT` is ignored and does not count.
- At most one job is outstanding downstream at any time.
- Transform (with the feature macro defined, see Configuration):
  - `cikis_baslangic_degeri` = stored sonuc.
  - `cikis_yon` = ~stored yon.
  - `cikis_miktar` = (stored miktar == 7) ? 7 : stored miktar + 1 (saturating, never wraps to 0).
- **Reset** (`reset_n`=0 at an edge), including mid-operation:
  - FIFO emptied, pointers 0, FSM → `BOSTA`.
  - All outputs are forced to their reset values.
  - A `giris_hazir` at that edge is discarded.

## Timing
- Output reset values:
  - `cikis_basla`=0, `cikis_baslangic_degeri`=0, `cikis_yon`=0, `cikis_miktar`=0
  - `bos`=1, `dolu`=0, `sayi`=0, `tasma`=0, `tamamlanan`=0
- All outputs are registered; no combinational input→output path.
- **Latency (FIFO empty, FSM in `BOSTA`, `hedef_mesgul`=0):** `giris_hazir` high in cycle k gives `cikis_basla` high in cycle k+2 for exactly one cycle.
- `sayi`/`bos`/`dolu` reflect a push or pop from the cycle after the edge.
- **Back-to-back jobs:** `hedef_hazir` in cycle j gives the next `cikis_basla` no earlier than cycle j+2.
- **Simultaneous push and pop** on one edge: `sayi` is unchanged, including when full; no overflow.
- `hedef_mesgul`=1 in `BOSTA` stalls issue indefinitely; entries keep accumulating.

## Configuration
- Macro `SAYAC_KUYRUK_DONUSUM_EN`.
- **Defined:** yon inversion and saturating miktar+1 are applied as described in Operation.
- **Undefined:** fields pass through unchanged (`cikis_yon` = stored yon, `cikis_miktar` = stored miktar).
- Queueing, FSM and timing are identical in both builds.

## Test plan
- **Single job:** after reset, one `giris_hazir` with sonuc=136, yon=1, miktar=3 → `cikis_basla` 2 cycles later with 136/0/4; `hedef_hazir` pulse → `tamamlanan`=1, `bos`=1.
- **Saturation:** miktar=7, yon=0 → `cikis_miktar`=7, `cikis_yon`=1; repeat with the macro undefined → 7/0.
- **Fill and overflow:** `hedef_mesgul`=1, 5 consecutive pushes (values 10..14) with `DERINLIK`=4 → `dolu`=1 after the 4th push, `tasma`=1 after the 5th, `sayi`=4. After `hedef_mesgul`=0, the issued values are 10, 11, 12, 13 in order.
- **Full with simultaneous push/pop:** FIFO full, push on the same edge as an issue → `sayi` stays 4, `tasma` stays 0, the new entry is issued last.
- **Premature/idle `hedef_hazir`:** `hedef_hazir` pulsed in `BOSTA` and in `BASLAT` → no state change, `tamamlanan` unchanged.
- **Reset mid-operation:** 3 entries queued and FSM in `BEKLE`, `reset_n`=0 for one cycle → all reset values next cycle; a later single push completes normally.
